gpo_timed_dispatcher: RTL and testbench
=======================================

// Module: gpo_timed_dispatcher
// PURPOSE
//  Upstream stage of the GPO core. Buffers 128-bit timed entries {timestamp[127:64], payload[63:0]}
//  written from the AXI side in a FIFO and compares the head timestamp with a free-running 64-bit
//  timestamp counter. On a match it presents the entry on gpo_in and pulses counter_matched for
//  one cycle. Late entries and FIFO overflow are flagged, never silently executed.
// PARAMETERS
//  FIFO_ADDR_WIDTH  5     FIFO depth = 2**FIFO_ADDR_WIDTH entries
//  TS_WIDTH         64    timestamp counter width; entry bits [127:64] carry it
// PORTS
//  CLK100MHZ        in   1    system clock
//  reset_n          in   1    synchronous reset, active-low
//  s_valid          in   1    write entry valid
//  s_data           in   128  {timestamp, payload}
//  s_ready          out  1    ~fifo_full; a write happens when s_valid & s_ready
//  counter_en       in   1    counter increments by 1 per cycle while high
//  counter_clear    in   1    1-cycle pulse: counter <= 0
//  flush            in   1    1-cycle pulse: empties the FIFO; the counter is untouched
//  counter_value    out  64   current timestamp counter
//  gpo_in           out  128  dispatched entry (registered)
//  counter_matched  out  1    1-cycle dispatch strobe (to the GPO core)
//  fifo_count       out  FIFO_ADDR_WIDTH+1  occupancy
//  fifo_empty       out  1
//  late_error       out  1    1-cycle pulse: head entry dropped as late
//  overflow_error   out  1    sticky: write attempted while full; cleared by reset/flush
// BEHAVIOUR
//  - Reset: counter, fifo_count=0, gpo_in=0, counter_matched=0, late_error=0, overflow_error=0,
//    fifo_empty=1, s_ready=1. Reset mid-operation discards all queued entries and in-flight dispatch.
//  - Counter: counter_clear has priority over counter_en. Wraps 2**64-1 -> 0 with no flag.
//  - Head: first-word-fall-through register. Valid when the FIFO is non-empty.
//  - Dispatch: in cycle T, with head valid and head.ts == counter: pop the head.
//    In T+1: gpo_in = entry and counter_matched = 1. Latency is fixed at 1 cycle; software compensates.
//    gpo_in holds its value until the next dispatch.
//  - Late: head valid and $signed(head.ts - counter) < 0 (wrap-safe): pop, late_error=1 in T+1,
//    gpo_in unchanged, no counter_matched.
//  - Future head (difference > 0): hold; no output activity.
//  - Throughput: one pop per cycle. Entries with consecutive timestamps dispatch on consecutive cycles.
//  - Push and pop in the same cycle: fifo_count unchanged. A push into an empty FIFO is
//    compared no earlier than the following cycle.
//  - Full: s_ready=0. s_valid while full sets overflow_error; the data is dropped.
//  - flush: empties the FIFO and head, clears overflow_error, cancels the compare in that cycle.
//    A same-cycle write is dropped.
//  - Downstream busy/override is handled by the GPO core. The dispatcher never stalls on it.
// STRUCTURE
//  - Package gpo_pkg: gpo_entry_t struct {logic [63:0] ts; logic [63:0] payload;}, ENTRY_W=128,
//    and the TS_WIDTH default.
//  - Sub-module gpo_sync_fifo: single-clock FWFT FIFO (push/pop/flush, count, full/empty,
//    reset_n sync).
//  - The dispatcher holds the counter, the compare, and the output registers only.
// TESTING
//  1. Write ts=10/p=0xA, ts=11/p=0xB; counter_en from 0 -> counter_matched at counter=11 and 12,
//     gpo_in payload 0xA then 0xB, fifo_empty=1 after.
//  2. Counter at 50; write ts=20 -> late_error pulses once, no counter_matched, gpo_in unchanged.
//  3. Fill 32 entries ts=1000.., write a 33rd -> s_ready=0, overflow_error=1, fifo_count=32;
//     flush -> count=0, overflow_error=0.
//  4. counter_clear to 2**64-3 is not reachable, so force the counter via a bench hook to 2**64-2;
//     write ts=1 -> dispatched after the wrap, no late_error.
//  5. Assert reset_n=0 mid-stream with 5 entries queued -> next cycle all outputs at reset values,
//     fifo_count=0.
//  6. Push and pop in the same cycle at count=4 -> count stays 4, the dispatched entry is correct.

Source files
------------

// File: rtl/gpo_pkg.sv
// Shared types for the GPO timed dispatcher: the timed entry layout and timestamp width.
// Latency: n/a (types and a pure helper function only).
// Backpressure: n/a.
package gpo_pkg;

    localparam int TS_W      = 64;
    localparam int PAYLOAD_W = 64;
    localparam int ENTRY_W   = TS_W + PAYLOAD_W;

    // One timed entry as written from the AXI side: timestamp in the upper half
    typedef struct packed {
        logic [TS_W-1:0]      ts;
        logic [PAYLOAD_W-1:0] payload;
    } gpo_entry_t;

    // Wrap-safe "already passed": the head is late when (ts - counter) is negative
    // as a two's-complement number, i.e. the counter is within half a wrap past it.
    function automatic logic ts_is_late(input logic [TS_W-1:0] head_ts,
                                        input logic [TS_W-1:0] cnt);
        logic [TS_W-1:0] diff;
        diff = head_ts - cnt;
        return diff[TS_W-1];
    endfunction

endpackage

// File: rtl/gpo_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; head_dat shows the oldest entry while not empty.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: push ignored when full, pop ignored when empty; flush empties and wins over both.
module gpo_sync_fifo #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_dat,
    input  logic              pop,
    input  logic              flush,
    output logic [DATA_W-1:0] head_dat,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty
);

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              w_push;
    logic              w_pop;

    assign full     = (r_count == DEPTH);
    assign empty    = (r_count == '0);
    assign count    = r_count;
    assign head_dat = r_mem[r_rd_ptr];

    assign w_push = push & ~full  & ~flush & reset_n;
    assign w_pop  = pop  & ~empty & ~flush;

    // Storage array: written only on an accepted push, never reset
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_dat;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave the count unchanged
    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (ADDR_W+1)'(1);
                2'b01:   r_count <= r_count - (ADDR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/gpo_timed_dispatcher.sv
// Queues timed entries and dispatches the head when its timestamp equals the free-running counter.
// Latency: gpo_in/counter_matched (or late_error) appear 1 cycle after the matching compare.
// Backpressure: s_ready = not full; writes while full are dropped and flagged; never stalls downstream.
module gpo_timed_dispatcher
    import gpo_pkg::*;
#(
    parameter int FIFO_ADDR_WIDTH = 5,
    parameter int TS_WIDTH        = TS_W
) (
    input  logic                       CLK100MHZ,
    input  logic                       reset_n,
    input  logic                       s_valid,
    input  logic [ENTRY_W-1:0]         s_data,
    output logic                       s_ready,
    input  logic                       counter_en,
    input  logic                       counter_clear,
    input  logic                       flush,
    output logic [TS_WIDTH-1:0]        counter_value,
    output logic [ENTRY_W-1:0]         gpo_in,
    output logic                       counter_matched,
    output logic [FIFO_ADDR_WIDTH:0]   fifo_count,
    output logic                       fifo_empty,
    output logic                       late_error,
    output logic                       overflow_error
);

    logic [TS_WIDTH-1:0] r_counter;
    logic [ENTRY_W-1:0]  r_gpo_in;
    logic                r_matched;
    logic                r_late;
    logic                r_overflow;

    logic [TS_WIDTH-1:0] w_cnt_nxt;
    logic [ENTRY_W-1:0]  w_head_dat;
    gpo_entry_t          w_head;
    logic                w_full;
    logic                w_empty;
    logic                w_head_vld;
    logic                w_match;
    logic                w_late;
    logic                w_pop;
    logic                w_push;

    gpo_sync_fifo #(
        .ADDR_W (FIFO_ADDR_WIDTH),
        .DATA_W (ENTRY_W)
    ) u_fifo (
        .clk      (CLK100MHZ),
        .reset_n  (reset_n),
        .push     (w_push),
        .push_dat (s_data),
        .pop      (w_pop),
        .flush    (flush),
        .head_dat (w_head_dat),
        .count    (fifo_count),
        .full     (w_full),
        .empty    (w_empty)
    );

    assign w_head = gpo_entry_t'(w_head_dat);

    // A flush cancels this cycle's compare so nothing is dispatched from a discarded queue
    assign w_head_vld = ~w_empty & ~flush;
    assign w_match    = w_head_vld & (w_head.ts == r_counter);
    assign w_late     = w_head_vld & ts_is_late(w_head.ts, r_counter);
    assign w_pop      = w_match | w_late;
    assign w_push     = s_valid & ~w_full & ~flush;

    // Clear beats enable; the counter wraps silently
    assign w_cnt_nxt = counter_clear ? '0 :
                       counter_en    ? r_counter + TS_WIDTH'(1) : r_counter;

    // Free-running timestamp counter
    always_ff @(posedge CLK100MHZ) begin
        if (!reset_n) begin
            r_counter <= '0;
        end else begin
            r_counter <= w_cnt_nxt;
        end
    end

    // Dispatch outputs: gpo_in holds until the next match, strobes last one cycle
    always_ff @(posedge CLK100MHZ) begin
        if (!reset_n) begin
            r_gpo_in  <= '0;
            r_matched <= 1'b0;
            r_late    <= 1'b0;
        end else begin
            r_matched <= w_match;
            r_late    <= w_late;
            if (w_match) begin
                r_gpo_in <= w_head_dat;
            end
        end
    end

    // Sticky overflow flag: a write seen while full; flush or reset clears it
    always_ff @(posedge CLK100MHZ) begin
        if (!reset_n || flush) begin
            r_overflow <= 1'b0;
        end else if (s_valid && w_full) begin
            r_overflow <= 1'b1;
        end
    end

    assign s_ready         = ~w_full;
    assign fifo_empty      = w_empty;
    assign counter_value   = r_counter;
    assign gpo_in          = r_gpo_in;
    assign counter_matched = r_matched;
    assign late_error      = r_late;
    assign overflow_error  = r_overflow;

endmodule

// File: tb/tb_gpo_timed_dispatcher.sv
// Scoreboard bench for the timed dispatcher: queue-level reference model plus cycle monitor.
// Latency: expected dispatch/late events are tagged with the cycle they must appear in.
// Backpressure: the model mirrors full/overflow/flush behaviour at entry granularity.
module tb_gpo_timed_dispatcher;
    import gpo_pkg::*;

    logic          CLK100MHZ = 1'b0;
    logic          reset_n = 1'b0;
    logic          s_valid = 1'b0;
    logic [127:0]  s_data = '0;
    logic          s_ready;
    logic          counter_en = 1'b0;
    logic          counter_clear = 1'b0;
    logic          flush = 1'b0;
    logic [63:0]   counter_value;
    logic [127:0]  gpo_in;
    logic          counter_matched;
    logic [5:0]    fifo_count;
    logic          fifo_empty;
    logic          late_error;
    logic          overflow_error;

    always #5 CLK100MHZ = ~CLK100MHZ;

    gpo_timed_dispatcher dut (
        .CLK100MHZ       (CLK100MHZ),
        .reset_n         (reset_n),
        .s_valid         (s_valid),
        .s_data          (s_data),
        .s_ready         (s_ready),
        .counter_en      (counter_en),
        .counter_clear   (counter_clear),
        .flush           (flush),
        .counter_value   (counter_value),
        .gpo_in          (gpo_in),
        .counter_matched (counter_matched),
        .fifo_count      (fifo_count),
        .fifo_empty      (fifo_empty),
        .late_error      (late_error),
        .overflow_error  (overflow_error)
    );

    typedef struct {
        int           due;
        bit           late;
        logic [127:0] dat;
    } exp_t;

    exp_t          sb[$];
    logic [127:0]  m_q[$];
    logic [63:0]   m_cnt = '0;
    bit            m_ovf = 1'b0;
    logic [127:0]  m_gpo = '0;
    int            cyc = 0;
    bit            mon_on = 1'b0;
    int            n_tests = 0;
    int            n_fail = 0;
    bit            hook_req = 1'b0;
    bit            hook_on = 1'b0;
    logic [63:0]   hook_val = '0;

    always @(posedge CLK100MHZ) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares DUT outputs with the model state predicted for this edge
    always @(posedge CLK100MHZ) begin
        exp_t e;
        #1;
        if (mon_on) begin
            chk("counter_value", counter_value, m_cnt);
            chk("fifo_count", fifo_count, m_q.size());
            chk("fifo_empty", fifo_empty, m_q.size() == 0);
            chk("s_ready", s_ready, m_q.size() < 32);
            chk("overflow_error", overflow_error, m_ovf);
            chk("gpo_in", gpo_in, m_gpo);
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                chk("counter_matched", counter_matched, !e.late);
                chk("late_error", late_error, e.late);
                if (!e.late) chk("dispatched entry", gpo_in, e.dat);
            end else begin
                chk("counter_matched idle", counter_matched, 1'b0);
                chk("late_error idle", late_error, 1'b0);
            end
        end
    end

    // Drive one cycle of inputs and advance the reference model to the following edge
    task automatic step(input bit v, input logic [63:0] ts, input logic [63:0] pl,
                        input bit en, input bit clr, input bit fl, input bit rst);
        int          sz;
        logic [63:0] diff;
        bit          hooked;
        @(negedge CLK100MHZ);
        if (hook_on) begin
            release dut.w_cnt_nxt;
            hook_on = 1'b0;
        end
        s_valid       = v;
        s_data        = {ts, pl};
        counter_en    = en;
        counter_clear = clr;
        flush         = fl;
        reset_n       = !rst;
        hooked        = hook_req && !rst;
        if (hooked) begin
            force dut.w_cnt_nxt = hook_val;
            hook_on = 1'b1;
        end
        hook_req = 1'b0;
        if (rst) begin
            m_q.delete();
            m_cnt = '0;
            m_ovf = 1'b0;
            m_gpo = '0;
        end else begin
            sz = m_q.size();
            if (fl) begin
                m_q.delete();
                m_ovf = 1'b0;
            end else begin
                if (sz > 0) begin
                    diff = m_q[0][127:64] - m_cnt;
                    if (diff == 64'd0) begin
                        sb.push_back('{cyc + 1, 1'b0, m_q[0]});
                        m_gpo = m_q[0];
                        void'(m_q.pop_front());
                    end else if ($signed(diff) < 0) begin
                        sb.push_back('{cyc + 1, 1'b1, m_q[0]});
                        void'(m_q.pop_front());
                    end
                end
                if (v) begin
                    if (sz == 32) m_ovf = 1'b1;
                    else          m_q.push_back({ts, pl});
                end
            end
            if (hooked)   m_cnt = hook_val;
            else if (clr) m_cnt = '0;
            else if (en)  m_cnt = m_cnt + 64'd1;
        end
        mon_on = 1'b1;
    endtask

    task automatic idle(input int n, input bit en);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, en, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wr(input logic [63:0] ts, input logic [63:0] pl, input bit en);
        step(1'b1, ts, pl, en, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic settle();
        @(posedge CLK100MHZ);
        #2;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        settle();
        chk("reset s_ready", s_ready, 1'b1);
        chk("reset fifo_empty", fifo_empty, 1'b1);

        // Two consecutive timestamps dispatch on consecutive cycles
        wr(64'd10, 64'hA, 1'b0);
        wr(64'd11, 64'hB, 1'b0);
        idle(14, 1'b1);
        settle();
        chk("t1 last dispatch", gpo_in, {64'd11, 64'hB});
        chk("t1 drained", fifo_empty, 1'b1);

        // Late entry is dropped with a single late pulse
        hook_val = 64'd50; hook_req = 1'b1;
        idle(1, 1'b0);
        wr(64'd20, 64'hC, 1'b0);
        idle(3, 1'b0);
        settle();
        chk("t2 gpo unchanged", gpo_in[63:0], 64'hB);

        // Fill, overflow, flush
        for (int i = 0; i < 32; i++) wr(64'd1000 + 64'(i), 64'(i), 1'b0);
        wr(64'd1032, 64'h33, 1'b0);
        settle();
        chk("t3 s_ready full", s_ready, 1'b0);
        chk("t3 overflow", overflow_error, 1'b1);
        chk("t3 count full", fifo_count, 6'd32);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        settle();
        chk("t3 flushed count", fifo_count, 6'd0);
        chk("t3 overflow cleared", overflow_error, 1'b0);

        // Dispatch across the counter wrap
        hook_val = 64'hFFFF_FFFF_FFFF_FFFE; hook_req = 1'b1;
        idle(1, 1'b0);
        wr(64'd1, 64'hD, 1'b1);
        idle(6, 1'b1);
        settle();
        chk("t4 wrap dispatch", gpo_in, {64'd1, 64'hD});

        // Push and pop in the same cycle at count 4
        for (int i = 0; i < 4; i++) wr(64'd200 + 64'(i), 64'h200 + 64'(i), 1'b0);
        hook_val = 64'd200; hook_req = 1'b1;
        idle(1, 1'b0);
        wr(64'd300, 64'hE, 1'b0);
        settle();
        chk("t6 count held", fifo_count, 6'd4);
        chk("t6 dispatched", gpo_in, {64'd200, 64'h200});

        // Reset with five queued entries
        wr(64'd400, 64'hF, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        settle();
        chk("t5 count reset", fifo_count, 6'd0);
        chk("t5 gpo reset", gpo_in, 128'd0);

        // Randomized traffic around the counter value
        for (int i = 0; i < 3000; i++) begin
            logic [63:0] ts;
            ts = m_cnt + 64'($urandom_range(0, 12)) - 64'd3;
            step(($urandom_range(0, 99) < 55), ts, {32'h0, $urandom},
                 ($urandom_range(0, 99) < 80), ($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 99) < 2), ($urandom_range(0, 299) == 0));
        end
        idle(4, 1'b0);
        settle();
        chk("scoreboard drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
